// File: rtl/video_testcard_gen.sv
// video_testcard_gen
//   Progressive PAL-style composite testcard generator. A free-running
//   horizontal/vertical counter pair produces composite sync and a grey level
//   for an external resistor DAC. Four patterns are available (bars, checker,
//   grid, ramp); the selected pattern is latched once per frame, on the last
//   clock of the last line, so a frame never mixes two patterns.
//
// Ports
//   clk           in   system clock
//   i_rst_n       in   asynchronous active-low reset
//   i_mode[1:0]   in   pattern select: 0 bars, 1 checker, 2 grid, 3 ramp
//   o_sync        out  composite sync, 0 = sync tip
//   o_level       out  grey level, 0 = black, all ones = peak white
//   o_active      out  high during active picture
//   o_frame_start out  one-cycle pulse marking line 0, clock 0
//
// All outputs are registered and reflect the counter state one clock earlier.
module video_testcard_gen #(
  parameter int H_TOTAL     = 768,
  parameter int H_SYNC      = 56,
  parameter int H_ACT_START = 126,
  parameter int H_ACT_LEN   = 624,
  parameter int BAR_W       = 78,
  parameter int V_TOTAL     = 312,
  parameter int V_SYNC      = 3,
  parameter int V_ACT_START = 23,
  parameter int V_ACT_LEN   = 288,
  parameter int LEVEL_W     = 4,
  parameter int CHECK_LOG2  = 5,
  parameter int GRID_LOG2   = 5,
  parameter int RAMP_SHIFT  = 5
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_mode,
  output logic               o_sync,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_active,
  output logic               o_frame_start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int LEVEL_MAX = (2 ** LEVEL_W) - 1;

  // Width-matched constants; the end-of-window limits carry one extra bit so
  // a window that runs right up to the line/frame end cannot overflow.
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_C     = HW'(H_SYNC);
  localparam logic [HW-1:0] H_BROAD_END  = HW'(H_TOTAL - H_SYNC);
  localparam logic [VW-1:0] V_SYNC_C     = VW'(V_SYNC);
  localparam logic [HW-1:0] H_ACT_S      = HW'(H_ACT_START);
  localparam logic [HW:0]   H_ACT_E      = (HW+1)'(H_ACT_START + H_ACT_LEN);
  localparam logic [VW-1:0] V_ACT_S      = VW'(V_ACT_START);
  localparam logic [VW:0]   V_ACT_E      = (VW+1)'(V_ACT_START + V_ACT_LEN);
  localparam logic [HW-1:0] X_LAST       = HW'(H_ACT_LEN - 1);
  localparam logic [VW-1:0] Y_LAST       = VW'(V_ACT_LEN - 1);
  localparam logic [HW-1:0] BAR_LAST     = HW'(BAR_W - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

  // Ramp level: x >> RAMP_SHIFT, clipped to peak white.
  function automatic logic [LEVEL_W-1:0] ramp_sat(input logic [HW-1:0] x);
    logic [HW-1:0] r;
    r = x >> RAMP_SHIFT;
    if (int'(r) > LEVEL_MAX) return LVL_MAX;
    return LEVEL_W'(r);
  endfunction

  // Bar 0 is brightest; the 3-bit bar brightness is placed in the level MSBs.
  function automatic logic [LEVEL_W-1:0] bar_level(input logic [2:0] bar);
    logic [2:0] inv;
    inv = 3'd7 - bar;
    return LEVEL_W'(inv) << (LEVEL_W - 3);
  endfunction

  logic [HW-1:0] h_p0;
  logic [VW-1:0] v_p0;
  logic [1:0]    mode_q;
  logic [HW-1:0] bar_pos_p0;
  logic [2:0]    bar_idx_p0;

  logic               h_wrap, v_wrap;
  logic [HW-1:0]      h_next;
  logic               h_act, v_act, act_c;
  logic [HW-1:0]      x_c;
  logic [VW-1:0]      y_c;
  logic               sync_c;
  logic [LEVEL_W-1:0] level_c;

  // ---- stage p0: timing counters decoded into sync/active/pattern ----
  always_comb begin
    h_wrap = (h_p0 == H_LAST);
    v_wrap = (v_p0 == V_LAST);
    h_next = h_wrap ? '0 : h_p0 + 1'b1;

    h_act  = (h_p0 >= H_ACT_S) && ({1'b0, h_p0} < H_ACT_E);
    v_act  = (v_p0 >= V_ACT_S) && ({1'b0, v_p0} < V_ACT_E);
    act_c  = h_act && v_act;
    x_c    = h_p0 - H_ACT_S;
    y_c    = v_p0 - V_ACT_S;

    // Vertical-sync lines carry broad pulses: long low, short high.
    if (v_p0 < V_SYNC_C) sync_c = (h_p0 >= H_BROAD_END);
    else                 sync_c = (h_p0 >= H_SYNC_C);

    level_c = '0;
    if (act_c) begin
      unique case (mode_q)
        2'd0: level_c = bar_level(bar_idx_p0);
        2'd1: level_c = (x_c[CHECK_LOG2] ^ y_c[CHECK_LOG2]) ? LVL_MAX : '0;
        2'd2: level_c = ((x_c[GRID_LOG2-1:0] == '0) || (y_c[GRID_LOG2-1:0] == '0) ||
                         (x_c == X_LAST) || (y_c == Y_LAST)) ? LVL_MAX : '0;
        default: level_c = ramp_sat(x_c);
      endcase
    end
  end

  // ---- stage p1: counter advance and registered outputs ----
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_p0          <= '0;
      v_p0          <= '0;
      mode_q        <= 2'd0;
      bar_pos_p0    <= '0;
      bar_idx_p0    <= 3'd0;
      o_sync        <= 1'b1;
      o_level       <= '0;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      h_p0 <= h_next;
      if (h_wrap) v_p0 <= v_wrap ? '0 : v_p0 + 1'b1;
      if (h_wrap && v_wrap) mode_q <= i_mode;

      // Bar counter tracks h so that bar_idx_p0 == x / BAR_W whenever h is
      // inside the active window; it restarts just before active start.
      if (h_next == H_ACT_S) begin
        bar_pos_p0 <= '0;
        bar_idx_p0 <= 3'd0;
      end else if (bar_pos_p0 == BAR_LAST) begin
        bar_pos_p0 <= '0;
        bar_idx_p0 <= bar_idx_p0 + 3'd1;
      end else begin
        bar_pos_p0 <= bar_pos_p0 + 1'b1;
      end

      o_sync        <= sync_c;
      o_level       <= level_c;
      o_active      <= act_c;
      o_frame_start <= (h_p0 == '0) && (v_p0 == '0);
    end
  end

endmodule
